// File: rtl/acq_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acq_seq_pkg
// Description : Shared state encoding and defaults for the line sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package acq_seq_pkg;

    localparam int c_ADDR_W_DEF = 32;
    localparam int c_LINE_W_DEF = 16;
    localparam int c_DLY_W_DEF  = 16;

    // Line length must be a whole number of 32-bit words.
    localparam logic [1:0] c_ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_FIRE   = 3'd2,
        S_DELAY  = 3'd3,
        S_GO     = 3'd4,
        S_XFER   = 3'd5,
        S_NEXT   = 3'd6,
        S_RGRANT = 3'd7
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/acq_delay_timer.sv
`default_nettype none
// ============================================================================
// Module      : acq_delay_timer
// Description : Loadable down-counter timing the tx_fire to write-go gap.
// Revision    : 1.0 - initial release
// ============================================================================
module acq_delay_timer #(
    parameter int DLY_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [DLY_W-1:0] i_load_val,
    output logic             o_load_zero,
    output logic             o_expire
);

    logic [DLY_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - DLY_W'(1);
        end
    end

    // A zero load skips the delay state entirely.
    assign o_load_zero = (i_load_val == '0);
    assign o_expire    = (r_count == DLY_W'(1));

endmodule
`default_nettype wire

// File: rtl/acq_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acq_line_sequencer
// Description : Sequences ultrasound line captures into SDRAM and arbitrates
//               SDRAM ownership between capture and SPI readout.
// Revision    : 1.0 - initial release
// ============================================================================
module acq_line_sequencer
    import acq_seq_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int LINE_W = c_LINE_W_DEF,
    parameter int DLY_W  = c_DLY_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_line_bytes,
    input  logic [LINE_W-1:0] cfg_num_lines,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic              write_control_done,
    input  logic              read_req,
    output logic [ADDR_W-1:0] control_write_base,
    output logic [ADDR_W-1:0] control_write_length,
    output logic              write_control_go,
    output logic              capture_en,
    output logic              tx_fire,
    output logic              read_grant,
    output logic              busy,
    output logic              seq_done,
    output logic              aborted,
    output logic              cfg_err,
    output logic [LINE_W-1:0] lines_done
);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_length;
    logic [LINE_W-1:0] r_num_lines;
    logic [LINE_W-1:0] r_lines_done;
    logic [DLY_W-1:0]  r_delay;
    logic              r_abort_pend;
    logic              r_tx_fire;
    logic              r_go;
    logic              r_capture;
    logic              r_busy;
    logic              r_seq_done;
    logic              r_aborted;
    logic              r_cfg_err;

    logic              w_cfg_bad;
    logic [LINE_W-1:0] w_lines_next;
    logic              w_delay_zero;
    logic              w_delay_expire;

    assign w_cfg_bad = (cfg_line_bytes == '0)
                    || ((cfg_line_bytes[1:0] & c_ALIGN_MASK) != 2'b00)
                    || (cfg_num_lines == '0);

    assign w_lines_next = r_lines_done + LINE_W'(1);

    acq_delay_timer #(
        .DLY_W (DLY_W)
    ) u_delay_timer (
        .clk         (clk),
        .reset       (reset),
        .i_load      (r_state == S_FIRE),
        .i_dec       (r_state == S_DELAY),
        .i_load_val  (r_delay),
        .o_load_zero (w_delay_zero),
        .o_expire    (w_delay_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_length     <= '0;
            r_num_lines  <= '0;
            r_lines_done <= '0;
            r_delay      <= '0;
            r_abort_pend <= 1'b0;
            r_tx_fire    <= 1'b0;
            r_go         <= 1'b0;
            r_capture    <= 1'b0;
            r_busy       <= 1'b0;
            r_seq_done   <= 1'b0;
            r_aborted    <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_tx_fire  <= 1'b0;
            r_go       <= 1'b0;
            r_seq_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // busy rises only for a start that ARM will accept.
                        r_state <= S_ARM;
                        r_busy  <= ~w_cfg_bad;
                    end else if (read_req) begin
                        r_state <= S_RGRANT;
                    end
                end
                S_ARM: begin
                    r_aborted    <= 1'b0;
                    r_lines_done <= '0;
                    r_abort_pend <= 1'b0;
                    if (w_cfg_bad) begin
                        r_cfg_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cfg_err   <= 1'b0;
                        r_base      <= cfg_base;
                        r_length    <= cfg_line_bytes;
                        r_num_lines <= cfg_num_lines;
                        r_delay     <= cfg_delay;
                        r_busy      <= 1'b1;
                        r_tx_fire   <= 1'b1;
                        r_state     <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    if (abort) begin
                        r_aborted  <= 1'b1;
                        r_seq_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_delay_zero) begin
                        r_go      <= 1'b1;
                        r_capture <= 1'b1;
                        r_state   <= S_GO;
                    end else begin
                        r_state <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (abort) begin
                        r_aborted  <= 1'b1;
                        r_seq_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_delay_expire) begin
                        r_go      <= 1'b1;
                        r_capture <= 1'b1;
                        r_state   <= S_GO;
                    end
                end
                S_GO: begin
                    // Done in the go cycle belongs to no transaction of ours.
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    r_state <= S_XFER;
                end
                S_XFER: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (write_control_done) begin
                        r_capture <= 1'b0;
                        r_state   <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_lines_done <= w_lines_next;
                    r_base       <= r_base + r_length;
                    if ((w_lines_next == r_num_lines) || r_abort_pend || abort) begin
                        r_aborted    <= r_abort_pend | abort;
                        r_abort_pend <= 1'b0;
                        r_seq_done   <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_tx_fire <= 1'b1;
                        r_state   <= S_FIRE;
                    end
                end
                S_RGRANT: begin
                    if (!read_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign control_write_base   = r_base;
    assign control_write_length = r_length;
    assign write_control_go     = r_go;
    assign capture_en           = r_capture;
    assign tx_fire              = r_tx_fire;
    // Grant follows read_req directly so it drops in the same cycle.
    assign read_grant           = (r_state == S_RGRANT) && read_req;
    assign busy                 = r_busy;
    assign seq_done             = r_seq_done;
    assign aborted              = r_aborted;
    assign cfg_err              = r_cfg_err;
    assign lines_done           = r_lines_done;

endmodule
`default_nettype wire

// File: tb/tb_acq_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_line_sequencer
// Description : Self-checking bench for acq_line_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_line_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_base = '0;
    logic [31:0] cfg_line_bytes = '0;
    logic [15:0] cfg_num_lines = '0;
    logic [15:0] cfg_delay = '0;
    logic        write_control_done = 1'b0;
    logic        read_req = 1'b0;
    logic [31:0] control_write_base;
    logic [31:0] control_write_length;
    logic        write_control_go;
    logic        capture_en;
    logic        tx_fire;
    logic        read_grant;
    logic        busy;
    logic        seq_done;
    logic        aborted;
    logic        cfg_err;
    logic [15:0] lines_done;

    acq_line_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .abort                (abort),
        .cfg_base             (cfg_base),
        .cfg_line_bytes       (cfg_line_bytes),
        .cfg_num_lines        (cfg_num_lines),
        .cfg_delay            (cfg_delay),
        .write_control_done   (write_control_done),
        .read_req             (read_req),
        .control_write_base   (control_write_base),
        .control_write_length (control_write_length),
        .write_control_go     (write_control_go),
        .capture_en           (capture_en),
        .tx_fire              (tx_fire),
        .read_grant           (read_grant),
        .busy                 (busy),
        .seq_done             (seq_done),
        .aborted              (aborted),
        .cfg_err              (cfg_err),
        .lines_done           (lines_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vectors = 0;
    int          miscompares = 0;
    int          tx_q[$];
    int          go_q[$];
    logic [31:0] gob_q[$];
    logic [31:0] gol_q[$];
    int          sd_q[$];
    int          gr_q[$];
    int          busy_cnt = 0;
    int          overlap = 0;
    int          done_lat = 4;
    bit          done_early = 1'b0;

    // Event recorder: everything observed at the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_fire) tx_q.push_back(cyc);
            if (write_control_go) begin
                go_q.push_back(cyc);
                gob_q.push_back(control_write_base);
                gol_q.push_back(control_write_length);
            end
            if (seq_done) sd_q.push_back(cyc);
            if (read_grant) gr_q.push_back(cyc);
            if (busy) busy_cnt++;
            if (read_grant && capture_en) overlap++;
        end
    end

    // Write-master model: done pulse done_lat cycles after each go.
    initial begin
        forever begin
            @(negedge clk);
            if (write_control_go && !reset) begin
                if (done_early && done_lat >= 2) begin
                    write_control_done = 1'b1;
                    @(negedge clk);
                    write_control_done = 1'b0;
                    repeat (done_lat - 1) @(negedge clk);
                end else begin
                    repeat (done_lat) @(negedge clk);
                end
                write_control_done = 1'b1;
                @(negedge clk);
                write_control_done = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_seq_done(input int limit);
        while (sd_q.size() == 0 && cyc < limit) step();
    endtask

    task automatic clear_queues();
        tx_q.delete(); go_q.delete(); gob_q.delete(); gol_q.delete();
        sd_q.delete(); gr_q.delete();
        busy_cnt = 0;
    endtask

    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({tx_fire, write_control_go, capture_en, read_grant, busy, seq_done, aborted, cfg_err} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {tx_fire, write_control_go, capture_en, read_grant, busy, seq_done, aborted, cfg_err});
        end
        vectors++;
        if (control_write_base !== 32'h0 || control_write_length !== 32'h0 || lines_done !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_regs: base %h len %h lines %0d want all 0",
                     control_write_base, control_write_length, lines_done);
        end
    endtask

    // Normal multi-line sequence against an arithmetic timing/address model.
    task automatic test_sequence(input logic [31:0] base, input logic [31:0] bytes,
                                 input int lines, input int dly, input int lat, input bit early);
        int s, period, exp_tx, exp_go, exp_sd;
        logic [31:0] exp_base;
        clear_queues();
        done_lat = lat;
        done_early = early;
        cfg_base = base;
        cfg_line_bytes = bytes;
        cfg_num_lines = 16'(lines);
        cfg_delay = 16'(dly);
        period = dly + lat + 3;
        pulse_start(s);
        wait_seq_done(s + lines * period + 40);
        repeat (3) step();
        exp_sd = s + 2 + (lines - 1) * period + 1 + dly + lat + 2;

        vectors++;
        if (tx_q.size() != lines || go_q.size() != lines) begin
            miscompares++;
            $display("FAIL seq_count: tx %0d go %0d want %0d", tx_q.size(), go_q.size(), lines);
        end
        for (int k = 0; k < lines; k++) begin
            exp_tx = s + 2 + k * period;
            exp_go = exp_tx + 1 + dly;
            exp_base = base + bytes * k;
            if (k < tx_q.size()) begin
                vectors++;
                if (tx_q[k] != exp_tx) begin
                    miscompares++;
                    $display("FAIL tx_time[%0d]: got %0d want %0d", k, tx_q[k], exp_tx);
                end
            end
            if (k < go_q.size()) begin
                vectors++;
                if (go_q[k] != exp_go || gob_q[k] !== exp_base || gol_q[k] !== bytes) begin
                    miscompares++;
                    $display("FAIL go[%0d]: cyc %0d base %h len %h want cyc %0d base %h len %h",
                             k, go_q[k], gob_q[k], gol_q[k], exp_go, exp_base, bytes);
                end
            end
        end
        vectors++;
        if (sd_q.size() != 1 || (sd_q.size() == 1 && sd_q[0] != exp_sd)) begin
            miscompares++;
            $display("FAIL seq_done: count %0d first %0d want 1 at %0d",
                     sd_q.size(), (sd_q.size() > 0) ? sd_q[0] : -1, exp_sd);
        end
        vectors++;
        if (lines_done !== 16'(lines) || aborted !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_status: lines %0d ab %b err %b busy %b want %0d 0 0 0",
                     lines_done, aborted, cfg_err, busy, lines);
        end
        vectors++;
        if (busy_cnt != exp_sd - 1 - s) begin
            miscompares++;
            $display("FAIL busy_len: got %0d want %0d", busy_cnt, exp_sd - 1 - s);
        end
    endtask

    task automatic test_cfg_err(input logic [31:0] bytes, input int lines);
        int s;
        clear_queues();
        cfg_base = 32'h2000;
        cfg_line_bytes = bytes;
        cfg_num_lines = 16'(lines);
        cfg_delay = 16'd2;
        pulse_start(s);
        repeat (12) step();
        vectors++;
        if (cfg_err !== 1'b1 || tx_q.size() != 0 || go_q.size() != 0 || busy_cnt != 0) begin
            miscompares++;
            $display("FAIL cfg_reject(bytes=%0d lines=%0d): err %b tx %0d go %0d busy %0d want 1 0 0 0",
                     bytes, lines, cfg_err, tx_q.size(), go_q.size(), busy_cnt);
        end
    endtask

    task automatic test_abort_delay();
        int s, tx1;
        clear_queues();
        done_lat = 3; done_early = 1'b0;
        cfg_base = 32'h4000; cfg_line_bytes = 32'd128;
        cfg_num_lines = 16'd3; cfg_delay = 16'd8;
        pulse_start(s);
        tx1 = s + 2 + (8 + 3 + 3);
        wait_cycle(tx1 + 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (20) step();
        vectors++;
        if (tx_q.size() != 2 || go_q.size() != 1) begin
            miscompares++;
            $display("FAIL abort_delay_cmds: tx %0d go %0d want 2 1", tx_q.size(), go_q.size());
        end
        vectors++;
        if (sd_q.size() != 1 || (sd_q.size() == 1 && sd_q[0] != tx1 + 4)) begin
            miscompares++;
            $display("FAIL abort_delay_done: count %0d at %0d want 1 at %0d",
                     sd_q.size(), (sd_q.size() > 0) ? sd_q[0] : -1, tx1 + 4);
        end
        vectors++;
        if (aborted !== 1'b1 || lines_done !== 16'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_delay_status: ab %b lines %0d busy %b want 1 1 0", aborted, lines_done, busy);
        end
    endtask

    task automatic test_abort_xfer();
        int s, go1;
        clear_queues();
        done_lat = 5; done_early = 1'b0;
        cfg_base = 32'h8000; cfg_line_bytes = 32'd256;
        cfg_num_lines = 16'd3; cfg_delay = 16'd2;
        pulse_start(s);
        go1 = s + 2 + (2 + 5 + 3) + 1 + 2;
        wait_cycle(go1 + 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (20) step();
        vectors++;
        if (tx_q.size() != 2 || go_q.size() != 2) begin
            miscompares++;
            $display("FAIL abort_xfer_cmds: tx %0d go %0d want 2 2", tx_q.size(), go_q.size());
        end
        vectors++;
        if (sd_q.size() != 1 || (sd_q.size() == 1 && sd_q[0] != go1 + 5 + 2)) begin
            miscompares++;
            $display("FAIL abort_xfer_done: count %0d at %0d want 1 at %0d",
                     sd_q.size(), (sd_q.size() > 0) ? sd_q[0] : -1, go1 + 7);
        end
        vectors++;
        if (aborted !== 1'b1 || lines_done !== 16'd2) begin
            miscompares++;
            $display("FAIL abort_xfer_status: ab %b lines %0d want 1 2", aborted, lines_done);
        end
    endtask

    task automatic test_read_arbitration();
        int s, sd;
        clear_queues();
        done_lat = 2; done_early = 1'b0;
        cfg_base = 32'h100; cfg_line_bytes = 32'd16;
        cfg_num_lines = 16'd2; cfg_delay = 16'd1;
        read_req = 1'b1;
        pulse_start(s);
        wait_seq_done(s + 60);
        sd = (sd_q.size() > 0) ? sd_q[0] : -1;
        step();
        vectors++;
        if (sd < 0 || tx_q.size() != 2 || gr_q.size() != 1 || gr_q[0] != sd + 1 || read_grant !== 1'b1) begin
            miscompares++;
            $display("FAIL grant_after_seq: sd %0d tx %0d grants %0d first %0d now %b want grant at %0d",
                     sd, tx_q.size(), gr_q.size(), (gr_q.size() > 0) ? gr_q[0] : -1, read_grant, sd + 1);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || read_grant !== 1'b1 || capture_en !== 1'b0) begin
            miscompares++;
            $display("FAIL grant_hold: busy %b grant %b cap %b want 0 1 0", busy, read_grant, capture_en);
        end
        read_req = 1'b0;
        #1;
        vectors++;
        if (read_grant !== 1'b0) begin
            miscompares++;
            $display("FAIL grant_drop: got %b want 0", read_grant);
        end
        repeat (6) step();
        vectors++;
        if (tx_q.size() != 2 || busy !== 1'b0 || read_grant !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_grant: tx %0d busy %b grant %b want 2 0 0", tx_q.size(), busy, read_grant);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int s;
        clear_queues();
        done_lat = 6; done_early = 1'b0;
        cfg_base = 32'h3000; cfg_line_bytes = 32'd64;
        cfg_num_lines = 16'd3; cfg_delay = 16'd2;
        pulse_start(s);
        while (go_q.size() == 0 && cyc < s + 30) step();
        step();
        step();
        vectors++;
        if (capture_en !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_capture: got %b want 1", capture_en);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({tx_fire, write_control_go, capture_en, read_grant, busy, seq_done, aborted, cfg_err} !== 8'h00
            || control_write_base !== 32'h0 || control_write_length !== 32'h0 || lines_done !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset: flags %b base %h len %h lines %0d want all 0",
                     {tx_fire, write_control_go, capture_en, read_grant, busy, seq_done, aborted, cfg_err},
                     control_write_base, control_write_length, lines_done);
        end
        step();
        step();
        reset = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();
        test_reset();

        test_sequence(32'h0000_1000, 32'd64, 3, 5, 4, 1'b0);
        test_sequence(32'hFFFF_FFC0, 32'd64, 2, 0, 1, 1'b0);
        test_sequence(32'h0000_0200, 32'd8, 2, 1, 3, 1'b1);

        test_cfg_err(32'd62, 2);
        test_cfg_err(32'd64, 0);
        test_cfg_err(32'd0, 1);
        test_sequence(32'h0001_0000, 32'd32, 1, 3, 2, 1'b0);

        test_abort_delay();
        test_abort_xfer();
        test_read_arbitration();

        for (int i = 0; i < 5; i++) begin
            test_sequence({$urandom, 2'b00} & 32'hFFFF_FFFC,
                          32'($urandom_range(64, 1)) << 2,
                          int'($urandom_range(4, 1)),
                          int'($urandom_range(6, 0)),
                          int'($urandom_range(6, 1)),
                          1'($urandom_range(1, 0)));
        end

        test_reset_mid_xfer();
        test_sequence(32'h0000_5000, 32'd64, 2, 2, 3, 1'b0);

        vectors++;
        if (overlap != 0) begin
            miscompares++;
            $display("FAIL grant_capture_overlap: got %0d cycles want 0", overlap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
